// File: rtl/ristretto_shift_dispatch.sv
// Single-issue shift dispatcher: resolves trivial shifts internally and hands the
// rest to an external multi-cycle shift unit, guarding it with a cycle timeout.
module ristretto_shift_dispatch #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxShiftCycles = 40
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [DataWidth-1:0] issue_operand_a_i,
  input  logic [DataWidth-1:0] issue_operand_b_i,
  input  logic [1:0]           issue_mode_i,
  input  logic [4:0]           issue_rd_i,
  input  logic                 flush_i,
  output logic                 shu_en_o,
  output logic [DataWidth-1:0] shu_operand_a_o,
  output logic [4:0]           shu_operand_b_o,
  output logic [1:0]           shu_mode_o,
  input  logic                 shu_busy_i,
  input  logic [DataWidth-1:0] shu_result_i,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [DataWidth-1:0] wb_result_o,
  output logic [4:0]           wb_rd_o,
  output logic                 timeout_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam int unsigned CntW = $clog2(MaxShiftCycles + 1);

  logic [1:0]           state_q, state_d;
  logic [DataWidth-1:0] op_a_q, op_a_d;
  logic [4:0]           amt_q, amt_d;
  logic [1:0]           mode_q, mode_d;
  logic [4:0]           rd_q, rd_d;
  logic [DataWidth-1:0] result_q, result_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 fast_path;
  logic [DataWidth-1:0] fast_res;

  // Amounts 0/1 and pass-through never need the shift unit.
  always_comb begin
    fast_path = (issue_mode_i == 2'b11) || (issue_operand_b_i[4:1] == 4'd0);
    fast_res  = issue_operand_a_i;
    if (issue_mode_i != 2'b11 && issue_operand_b_i[0]) begin
      case (issue_mode_i)
        2'b00:   fast_res = issue_operand_a_i << 1;
        2'b01:   fast_res = issue_operand_a_i >> 1;
        default: fast_res = {issue_operand_a_i[DataWidth-1], issue_operand_a_i[DataWidth-1:1]};
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    amt_d     = amt_q;
    mode_d    = mode_q;
    rd_d      = rd_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (issue_valid_i) begin
            op_a_d   = issue_operand_a_i;
            amt_d    = issue_operand_b_i[4:0];
            mode_d   = issue_mode_i;
            rd_d     = issue_rd_i;
            result_d = fast_res;
            cnt_d    = '0;
            state_d  = fast_path ? StDone : StExec;
          end
        end
        StExec: begin
          cnt_d = cnt_q + CntW'(1);
          // The unit's busy flag is not yet meaningful in the first EXEC cycle.
          if (cnt_q != '0 && !shu_busy_i) begin
            result_d = shu_result_i;
            state_d  = StDone;
          end else if (cnt_d == CntW'(MaxShiftCycles)) begin
            result_d  = '0;
            timeout_d = 1'b1;
            state_d   = StDone;
          end
        end
        StDone: begin
          if (wb_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      amt_q     <= '0;
      mode_q    <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      amt_q     <= amt_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign issue_ready_o   = (state_q == StIdle);
  assign shu_en_o        = (state_q == StExec);
  assign wb_valid_o      = (state_q == StDone);
  assign shu_operand_a_o = op_a_q;
  assign shu_operand_b_o = amt_q;
  assign shu_mode_o      = mode_q;
  assign wb_result_o     = result_q;
  assign wb_rd_o         = rd_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_ristretto_shift_dispatch.sv
// Randomized bench for ristretto_shift_dispatch with a behavioural shift-unit stand-in.
module tb_ristretto_shift_dispatch;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXC = 40;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          issue_valid_i = 1'b0;
  logic          issue_ready_o;
  logic [DW-1:0] issue_operand_a_i = '0;
  logic [DW-1:0] issue_operand_b_i = '0;
  logic [1:0]    issue_mode_i = '0;
  logic [4:0]    issue_rd_i = '0;
  logic          flush_i = 1'b0;
  logic          shu_en_o;
  logic [DW-1:0] shu_operand_a_o;
  logic [4:0]    shu_operand_b_o;
  logic [1:0]    shu_mode_o;
  logic          shu_busy_i = 1'b0;
  logic [DW-1:0] shu_result_i = '0;
  logic          wb_valid_o;
  logic          wb_ready_i = 1'b0;
  logic [DW-1:0] wb_result_o;
  logic [4:0]    wb_rd_o;
  logic          timeout_o;

  ristretto_shift_dispatch #(.DataWidth(DW), .MaxShiftCycles(MAXC)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_operand_a_i(issue_operand_a_i), .issue_operand_b_i(issue_operand_b_i),
    .issue_mode_i(issue_mode_i), .issue_rd_i(issue_rd_i), .flush_i(flush_i),
    .shu_en_o(shu_en_o), .shu_operand_a_o(shu_operand_a_o), .shu_operand_b_o(shu_operand_b_o),
    .shu_mode_o(shu_mode_o), .shu_busy_i(shu_busy_i), .shu_result_i(shu_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
    .wb_rd_o(wb_rd_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] a, input logic [4:0] s,
                                              input logic [1:0] m);
    case (m)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return DW'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  // Shift-unit stand-in: busy for busy_len cycles from the second EXEC cycle
  // (or forever when stuck); result is garbage whenever it must not be captured.
  int unsigned busy_len = 0;
  bit          stuck = 1'b0;
  int unsigned ucnt = 0;
  logic [38:0] op0;
  always @(negedge clk) begin
    if (shu_en_o) begin
      shu_busy_i = stuck || (ucnt >= 1 && ucnt <= busy_len);
      shu_result_i = (shu_busy_i || ucnt == 0) ? DW'($urandom)
                                               : ref_shift(shu_operand_a_o, shu_operand_b_o, shu_mode_o);
      if (ucnt == 0) op0 = {shu_operand_a_o, shu_operand_b_o, shu_mode_o};
      else check_eq("shu_operands_stable", {25'd0, shu_operand_a_o, shu_operand_b_o, shu_mode_o},
                    {25'd0, op0});
      ucnt++;
    end else begin
      ucnt = 0;
      shu_busy_i = 1'b0;
      shu_result_i = DW'($urandom);
    end
  end

  bit tmo_exp = 1'b0;

  task automatic issue_only(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [1:0] m, input logic [4:0] rd);
    @(negedge clk);
    issue_valid_i = 1'b1;
    issue_operand_a_i = a; issue_operand_b_i = b; issue_mode_i = m; issue_rd_i = rd;
    @(negedge clk);
    issue_valid_i = 1'b0;
    issue_operand_a_i = DW'($urandom); issue_operand_b_i = DW'($urandom);
    issue_mode_i = 2'($urandom); issue_rd_i = 5'($urandom);
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] m,
                        input logic [4:0] rd, input int unsigned blen, input bit stk,
                        input int unsigned wbdly);
    logic [DW-1:0] exp;
    bit            fast;
    int unsigned   exp_exec, cyc, en_cnt;
    fast     = (m == 2'b11) || (b[4:0] < 5'd2);
    exp      = (stk && !fast) ? '0 : ref_shift(a, b[4:0], m);
    exp_exec = fast ? 0 : (stk ? MAXC : (blen == 0 ? 2 : blen + 2));
    if (stk && !fast) tmo_exp = 1'b1;
    busy_len = blen; stuck = stk; wb_ready_i = 1'b0;
    check_eq("ready_before_issue", 64'(issue_ready_o), 64'd1);
    issue_only(a, b, m, rd);
    cyc = 0; en_cnt = 0;
    while (!wb_valid_o && cyc < 200) begin
      if (shu_en_o) en_cnt++;
      @(negedge clk);
      cyc++;
    end
    check_eq("wb_valid_seen", 64'(wb_valid_o), 64'd1);
    check_eq("exec_cycles", 64'(en_cnt), 64'(exp_exec));
    check_eq("wb_result", 64'(wb_result_o), 64'(exp));
    check_eq("wb_rd", 64'(wb_rd_o), 64'(rd));
    check_eq("timeout", 64'(timeout_o), 64'(tmo_exp));
    repeat (wbdly) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(wb_valid_o), 64'd1);
      check_eq("hold_result", 64'(wb_result_o), 64'(exp));
      check_eq("hold_rd", 64'(wb_rd_o), 64'(rd));
      check_eq("hold_not_ready", 64'(issue_ready_o), 64'd0);
    end
    // Request offered in the handshake cycle must not be taken.
    wb_ready_i = 1'b1;
    issue_valid_i = 1'b1; issue_mode_i = 2'b11;
    @(negedge clk);
    wb_ready_i = 1'b0; issue_valid_i = 1'b0;
    check_eq("post_wb_valid", 64'(wb_valid_o), 64'd0);
    check_eq("post_wb_ready", 64'(issue_ready_o), 64'd1);
    check_eq("post_wb_en", 64'(shu_en_o), 64'd0);
    stuck = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, 64'(issue_ready_o), 64'd1);
    check_eq({tag, "_en"}, 64'(shu_en_o), 64'd0);
    check_eq({tag, "_valid"}, 64'(wb_valid_o), 64'd0);
    check_eq({tag, "_timeout"}, 64'(timeout_o), 64'd0);
    check_eq({tag, "_shu_ops"}, {25'd0, shu_operand_a_o, shu_operand_b_o, shu_mode_o}, 64'd0);
    check_eq({tag, "_wb"}, {27'd0, wb_result_o, wb_rd_o}, 64'd0);
  endtask

  initial begin
    logic [DW-1:0] b;
    rstn_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rstn_i = 1'b1;

    run_op(32'h0000_0001, 32'd1, 2'b00, 5'd3, 0, 0, 0);
    run_op(32'h8000_0000, 32'd4, 2'b10, 5'd17, 3, 0, 0);
    run_op(32'h1234_5678, 32'd7, 2'b11, 5'd9, 0, 0, 0);
    run_op(32'hDEAD_BEEF, 32'd12, 2'b01, 5'd30, 2, 0, 5);
    run_op(32'hF000_000F, 32'hFFFF_FFE1, 2'b10, 5'd4, 1, 0, 1);

    // Flush in IDLE blocks acceptance of a fast op.
    @(negedge clk);
    issue_valid_i = 1'b1; issue_mode_i = 2'b11; flush_i = 1'b1;
    @(negedge clk);
    issue_valid_i = 1'b0; flush_i = 1'b0;
    check_eq("flush_idle_valid", 64'(wb_valid_o), 64'd0);
    check_eq("flush_idle_ready", 64'(issue_ready_o), 64'd1);

    // Flush during EXEC.
    busy_len = 5;
    issue_only(32'hCAFE_0000, 32'd9, 2'b01, 5'd12);
    @(negedge clk);
    check_eq("exec_before_flush", 64'(shu_en_o), 64'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("flush_exec_en", 64'(shu_en_o), 64'd0);
    check_eq("flush_exec_ready", 64'(issue_ready_o), 64'd1);
    repeat (8) begin
      @(negedge clk);
      check_eq("flush_exec_no_wb", 64'(wb_valid_o), 64'd0);
    end
    run_op(32'h0F0F_0F0F, 32'd5, 2'b00, 5'd21, 2, 0, 0);

    // Flush in DONE.
    issue_only(32'h0000_00FF, 32'd0, 2'b01, 5'd6);
    check_eq("done_before_flush", 64'(wb_valid_o), 64'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("flush_done_valid", 64'(wb_valid_o), 64'd0);
    check_eq("flush_done_ready", 64'(issue_ready_o), 64'd1);

    for (int i = 0; i < 40; i++) begin
      b = DW'($urandom);
      if ($urandom_range(0, 2) == 0) b[4:0] = 5'($urandom_range(0, 1));
      run_op(DW'($urandom), b, 2'($urandom_range(0, 3)), 5'($urandom), $urandom_range(0, 4), 0,
             $urandom_range(0, 3));
    end

    run_op(32'h1357_9BDF, 32'd6, 2'b00, 5'd19, 0, 1, 2);
    run_op(32'h0000_0010, 32'd3, 2'b01, 5'd2, 1, 0, 0);

    // Reset in the middle of EXEC discards the operation and clears timeout.
    busy_len = 6;
    issue_only(32'hABCD_1234, 32'd8, 2'b00, 5'd7);
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    tmo_exp = 1'b0;
    check_reset_state("midreset");
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("midreset_no_wb", 64'(wb_valid_o), 64'd0);
    end
    run_op(32'h8000_0001, 32'd31, 2'b10, 5'd31, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
